// File: rtl/inst_fetch_queue_if.sv
// Bundle between the fetch queue, the instruction SRAM-like bus and decode.
// Handshakes: a request transfers when inst_sram_req & inst_sram_addr_ok, the address being
// held while req is up; a response transfers on every inst_sram_data_ok; an instruction moves
// to decode when fs_to_ds_valid & ds_allowin; redirect_valid is a single-cycle pulse.
interface inst_fetch_queue_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_adef;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  redirect_valid, redirect_pc, ds_allowin,
    output fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_adef
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output redirect_valid, redirect_pc, ds_allowin,
    input  fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_adef
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: pipelined word fetches into an IQ_DEPTH-entry queue feeding decode.
// Define FETCH_ADEF_EN to trap misaligned fetch addresses as adef entries instead of issuing them.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          IQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  inst_fetch_queue_if.master  bus,
  output logic                dbg_state_o
);
  localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);
`ifdef FETCH_ADEF_EN
  localparam bit ADEF_ON = 1'b1;
`else
  localparam bit ADEF_ON = 1'b0;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic          stale_q, stale_d;
  logic          halt_q, halt_d;

  logic [31:0]         ent_pc_q   [IQ_DEPTH];
  logic [31:0]         ent_inst_q [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] ent_adef_q;
  logic [IQ_DEPTH-1:0] ent_filled_q;

  logic        req, accept, head_vld, pop, drop, fill;
  logic        push_req, push_adef, push, redirect;
  logic [31:0] nxt_pc;

  function automatic logic misaligned(input logic [31:0] a);
    return ADEF_ON && (a[1:0] != 2'b00);
  endfunction

  assign redirect  = bus.redirect_valid;
  assign req       = (state_q == S_REQ);
  assign accept    = req & bus.inst_sram_addr_ok;
  assign head_vld  = (count_q != '0) & ent_filled_q[head_q];
  assign pop       = head_vld & bus.ds_allowin;
  assign drop      = bus.inst_sram_data_ok & (discard_q != '0);
  assign fill      = bus.inst_sram_data_ok & (discard_q == '0) & ~redirect;
  assign push_req  = accept & ~stale_q & ~redirect;
  // A misaligned fetch_pc only arises right after a redirect, so the queue holds no unfilled entry.
  assign push_adef = (state_q == S_IDLE) & ~redirect & ~halt_q & (count_q != DEPTH_C)
                   & misaligned(fetch_pc_q);
  assign push      = push_req | push_adef;
  assign nxt_pc    = redirect ? bus.redirect_pc : (stale_q ? fetch_pc_q : req_pc_q + 32'd4);

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          if (!misaligned(bus.redirect_pc)) begin
            state_d  = S_REQ;
            req_pc_d = bus.redirect_pc;
          end
        end else if (!halt_q && (count_q != DEPTH_C) && !misaligned(fetch_pc_q)) begin
          state_d  = S_REQ;
          req_pc_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (accept) begin
          if ((push_req && (count_q == DEPTH_C - CW'(1))) || misaligned(nxt_pc)) begin
            state_d = S_IDLE;
          end else begin
            req_pc_d = nxt_pc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    stale_d    = stale_q;
    halt_d     = halt_q;
    outst_d    = outst_q + OW'(accept) - OW'(bus.inst_sram_data_ok);
    discard_d  = discard_q;
    if (redirect) begin
      // Everything still in flight after this cycle's accept/response belongs to the old stream.
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      discard_d  = outst_d;
      stale_d    = req & ~accept;
      halt_d     = 1'b0;
    end else begin
      if (push_req) fetch_pc_d = req_pc_q + 32'd4;
      count_d   = count_q + CW'(push) - CW'(pop);
      head_d    = head_q + PW'(pop);
      tail_d    = tail_q + PW'(push);
      fill_d    = push_adef ? tail_q + PW'(1) : fill_q + PW'(fill);
      discard_d = discard_q + OW'(accept & stale_q) - OW'(drop);
      if (accept)    stale_d = 1'b0;
      if (push_adef) halt_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      stale_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      stale_q    <= stale_d;
      halt_q     <= halt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
      end
      ent_adef_q   <= '0;
      ent_filled_q <= '0;
    end else begin
      if (push) begin
        ent_pc_q[tail_q]     <= push_req ? req_pc_q : fetch_pc_q;
        ent_inst_q[tail_q]   <= '0;
        ent_adef_q[tail_q]   <= push_adef;
        ent_filled_q[tail_q] <= push_adef;
      end
      if (fill) begin
        ent_inst_q[fill_q]   <= bus.inst_sram_rdata;
        ent_filled_q[fill_q] <= 1'b1;
      end
    end
  end

  assign bus.inst_sram_req   = req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'd2;
  assign bus.inst_sram_wstrb = 4'd0;
  assign bus.inst_sram_wdata = 32'd0;
  assign bus.inst_sram_addr  = req_pc_q;
  assign bus.fs_to_ds_valid  = head_vld;
  assign bus.fs_to_ds_pc     = ent_pc_q[head_q];
  assign bus.fs_to_ds_inst   = ent_inst_q[head_q];
  assign bus.fs_to_ds_adef   = ent_adef_q[head_q];
  assign dbg_state_o         = state_q;
endmodule
